// File: rtl/mul_share_ctrl_pkg.sv
// mul_share_ctrl_pkg: shared FSM encoding, port ids and default sizes for the multiplier-sharing controller
package mul_share_ctrl_pkg;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;
    localparam logic PORT0       = 1'b0;
    localparam logic PORT1       = 1'b1;
    localparam int   DEF_WIDTH   = 32;
    localparam int   DEF_TIMEOUT = 31;
endpackage

// File: rtl/mul_share_ctrl_if.sv
// mul_share_ctrl_if: requester, response and core-side signals of the shared multiplier
interface mul_share_ctrl_if import mul_share_ctrl_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic               req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic               rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [2*WIDTH-1:0] rsp_data;
    logic               rsp_err;
    logic               mul_start, mul_done;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic [2*WIDTH-1:0] mul_p;
    logic               busy, err_timeout;
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, mul_done, mul_p,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        output mul_start, mul_a, mul_b, busy, err_timeout
    );
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, mul_done, mul_p,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        input  mul_start, mul_a, mul_b, busy, err_timeout
    );
endinterface

// File: rtl/mul_share_ctrl_rr_arb2.sv
// mul_share_ctrl_rr_arb2: two-way round-robin grant favouring the port not served last
module mul_share_ctrl_rr_arb2 import mul_share_ctrl_pkg::*; (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_i,
    output logic gnt_valid_o,
    output logic gnt_o
);
    // lone requester wins; on contention the port that was not granted last wins
    always_comb begin
        gnt_valid_o = valid0_i | valid1_i;
        gnt_o       = (valid0_i & valid1_i) ? ~last_i : (valid1_i ? PORT1 : PORT0);
    end
endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sharing of one multi-cycle signed multiplier core between two requesters
module mul_share_ctrl import mul_share_ctrl_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    mul_share_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_e             state_q;
    logic               owner_q, last_q, start_q, busy_q, rv0_q, rv1_q, err_q, to_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] data_q;
    logic               gnt_valid, gnt, idle, rsp_ack;

    mul_share_ctrl_rr_arb2 u_arb (
        .valid0_i    (bus.req0_valid),
        .valid1_i    (bus.req1_valid),
        .last_i      (last_q),
        .gnt_valid_o (gnt_valid),
        .gnt_o       (gnt)
    );

    // requests are offered only in IDLE; the owner's ready closes the response
    always_comb begin
        idle           = state_q == S_IDLE;
        bus.req0_ready = idle & gnt_valid & (gnt == PORT0);
        bus.req1_ready = idle & gnt_valid & (gnt == PORT1);
        rsp_ack        = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
    end

    assign bus.rsp0_valid  = rv0_q;
    assign bus.rsp1_valid  = rv1_q;
    assign bus.rsp_data    = data_q;
    assign bus.rsp_err     = err_q;
    assign bus.mul_start   = start_q;
    assign bus.mul_a       = a_q;
    assign bus.mul_b       = b_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = to_q;

    // transaction FSM: accept, pulse the core, wait with watchdog, hold the response until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= PORT0;
            last_q  <= PORT1;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (gnt_valid) begin
                    a_q     <= gnt ? bus.req1_a : bus.req0_a;
                    b_q     <= gnt ? bus.req1_b : bus.req0_b;
                    owner_q <= gnt;
                    last_q  <= gnt;
                    start_q <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    start_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: if (bus.mul_done) begin
                    data_q  <= bus.mul_p;
                    err_q   <= 1'b0;
                    rv0_q   <= ~owner_q;
                    rv1_q   <= owner_q;
                    state_q <= S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_q  <= '0;
                    err_q   <= 1'b1;
                    to_q    <= 1'b1;
                    rv0_q   <= ~owner_q;
                    rv1_q   <= owner_q;
                    state_q <= S_RESP;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                S_RESP: if (rsp_ack) begin
                    rv0_q   <= 1'b0;
                    rv1_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: self-checking bench for the shared multiplier controller
module tb_mul_share_ctrl;
    localparam int W  = 32;
    localparam int TO = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_share_ctrl_if #(.WIDTH(W)) bus ();
    mul_share_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int           port;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           k;
        logic [63:0]  p;
        logic         err;
        int           lat;
    } vec_t;
    vec_t tbl[6];

    int tests = 0, fails = 0, cyc = 0;
    logic v[2], rr[2], spur;
    logic [W-1:0] a[2], b[2];
    int next_k = 1;
    int rem = 0, core_k = 1;
    logic [63:0] core_p;
    bit out_q = 0, sticky = 0, eerr = 0;
    bit accepted[2];
    int owner = 0, acc_cyc = 0, lat = 0, last = 1;
    logic [W-1:0] ea, eb;
    logic [63:0] edata;
    int dacc_p[$], dacc_c[$], dexit_c[$];
    int rise_cyc[2];
    logic [63:0] rise_data[2];
    logic rise_err[2], prev_rv[2];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void drive();
        bus.req0_valid = v[0]; bus.req0_a = a[0]; bus.req0_b = b[0];
        bus.req1_valid = v[1]; bus.req1_a = a[1]; bus.req1_b = b[1];
        bus.rsp0_ready = rr[0]; bus.rsp1_ready = rr[1];
    endfunction

    // multiplier core: done exactly core_k cycles after the start cycle, never while idle unless spurious
    function automatic void core_model();
        bit in_wait;
        in_wait = out_q && cyc >= acc_cyc + 2 && cyc < acc_cyc + lat;
        bus.mul_done = spur && !in_wait;
        bus.mul_p = {$urandom, $urandom};
        if (bus.mul_start === 1'b1) begin
            rem = core_k;
            core_p = 64'($signed(bus.mul_a)) * 64'($signed(bus.mul_b));
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                bus.mul_done = 1'b1;
                bus.mul_p = core_p;
            end
        end
    endfunction

    // transaction-level expectations for the current cycle
    task automatic ref_check();
        bit e0, e1, on;
        e0 = !out_q && v[0] && (!v[1] || last == 1);
        e1 = !out_q && v[1] && (!v[0] || last == 0);
        on = out_q && cyc >= acc_cyc + lat;
        if (on && eerr) sticky = 1;
        chk("req0_ready", 64'(bus.req0_ready), 64'(e0));
        chk("req1_ready", 64'(bus.req1_ready), 64'(e1));
        chk("rsp0_valid", 64'(bus.rsp0_valid), 64'(on && owner == 0));
        chk("rsp1_valid", 64'(bus.rsp1_valid), 64'(on && owner == 1));
        chk("busy", 64'(bus.busy), 64'(out_q));
        chk("mul_start", 64'(bus.mul_start), 64'(out_q && cyc == acc_cyc + 1));
        chk("err_timeout", 64'(bus.err_timeout), 64'(sticky));
        if (out_q && !on) begin
            chk("mul_a", 64'(bus.mul_a), 64'(ea));
            chk("mul_b", 64'(bus.mul_b), 64'(eb));
        end
        if (on) begin
            chk("rsp_data", bus.rsp_data, edata);
            chk("rsp_err", 64'(bus.rsp_err), 64'(eerr));
        end
    endtask

    // effect of the coming clock edge on the transaction model
    function automatic void ref_advance();
        int p;
        accepted[0] = 0;
        accepted[1] = 0;
        if (!rst_n) begin
            out_q = 0; last = 1; sticky = 0;
            return;
        end
        if (out_q) begin
            if (cyc >= acc_cyc + lat && rr[owner]) out_q = 0;
        end else if (v[0] || v[1]) begin
            p = (v[0] && v[1]) ? 1 - last : (v[1] ? 1 : 0);
            out_q = 1; owner = p; acc_cyc = cyc; last = p;
            ea = a[p]; eb = b[p]; core_k = next_k;
            lat = 2 + (next_k < TO ? next_k : TO);
            eerr = next_k > TO;
            edata = eerr ? 64'd0 : 64'($signed(a[p])) * 64'($signed(b[p]));
            accepted[p] = 1;
        end
    endfunction

    task automatic step();
        drive();
        #1;
        if (rst_n) begin
            ref_check();
            if (bus.req0_valid && bus.req0_ready) begin dacc_p.push_back(0); dacc_c.push_back(cyc); end
            if (bus.req1_valid && bus.req1_ready) begin dacc_p.push_back(1); dacc_c.push_back(cyc); end
            if ((bus.rsp0_valid && rr[0]) || (bus.rsp1_valid && rr[1])) dexit_c.push_back(cyc);
        end
        for (int p = 0; p < 2; p++) begin
            logic rv;
            rv = p ? bus.rsp1_valid : bus.rsp0_valid;
            if (rv && !prev_rv[p]) begin
                rise_cyc[p] = cyc; rise_data[p] = bus.rsp_data; rise_err[p] = bus.rsp_err;
            end
            prev_rv[p] = rv;
        end
        ref_advance();
        @(negedge clk);
        cyc++;
        core_model();
    endtask

    task automatic send(int p, logic [W-1:0] aa, logic [W-1:0] bb, int k);
        int n = 0;
        v[p] = 1; a[p] = aa; b[p] = bb; next_k = k;
        do begin step(); n++; end while (!accepted[p] && n < 100);
        chk("accept_in_time", 64'(accepted[p]), 64'(1));
        v[p] = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (out_q && n < 200) begin step(); n++; end
        chk("idle_in_time", 64'(out_q), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        tbl[0] = '{0, 32'd7,          32'hFFFF_FFFD, 17, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 19};
        tbl[1] = '{1, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  1, 64'h3FFF_FFFF_0000_0001, 1'b0,  3};
        tbl[2] = '{0, 32'hFFFF_FFFF,  32'h8000_0000,  5, 64'h0000_0000_8000_0000, 1'b0,  7};
        tbl[3] = '{1, 32'h0001_0000,  32'hFFFF_0000, 31, 64'hFFFF_FFFF_0000_0000, 1'b0, 33};
        tbl[4] = '{0, 32'd5,          32'd6,         32, 64'h0,                   1'b1, 33};
        tbl[5] = '{1, 32'd0,          32'h1234_5678,  2, 64'h0,                   1'b0,  4};
        v = '{0, 0}; rr = '{1, 1}; a = '{0, 0}; b = '{0, 0}; spur = 0;
        prev_rv = '{0, 0}; rise_cyc = '{-1, -1};
        core_model();
        step();
        step();
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_rsp0_valid", 64'(bus.rsp0_valid), 64'(0));
        chk("rst_rsp1_valid", 64'(bus.rsp1_valid), 64'(0));
        chk("rst_mul_start", 64'(bus.mul_start), 64'(0));
        chk("rst_mul_a", 64'(bus.mul_a), 64'(0));
        chk("rst_mul_b", 64'(bus.mul_b), 64'(0));
        chk("rst_rsp_data", bus.rsp_data, 64'(0));
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
        chk("rst_err_timeout", 64'(bus.err_timeout), 64'(0));
        chk("rst_req0_ready", 64'(bus.req0_ready), 64'(0));
        rst_n = 1;

        for (int i = 0; i < 6; i++) begin
            rise_cyc[tbl[i].port] = -1;
            send(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].k);
            wait_idle();
            chk("tbl_latency", 64'(rise_cyc[tbl[i].port] - dacc_c[$]), 64'(tbl[i].lat));
            chk("tbl_data", rise_data[tbl[i].port], tbl[i].p);
            chk("tbl_err", 64'(rise_err[tbl[i].port]), 64'(tbl[i].err));
        end

        begin
            int base, ebase, n;
            base = dacc_p.size(); ebase = dexit_c.size(); n = 0;
            v = '{1, 1}; a = '{32'd3, 32'd4}; b = '{32'd5, 32'd6}; next_k = 3;
            while (dacc_p.size() - base < 4 && n < 200) begin
                step(); n++;
                for (int p = 0; p < 2; p++) if (accepted[p]) begin a[p] = $urandom; b[p] = $urandom; end
            end
            v = '{0, 0};
            wait_idle();
            chk("grant_count", 64'(dacc_p.size() - base), 64'(4));
            if (dacc_p.size() - base >= 4 && dexit_c.size() > ebase) begin
                for (int i = 0; i < 4; i++) chk("grant_order", 64'(dacc_p[base + i]), 64'(i % 2));
                chk("b2b_gap", 64'(dacc_c[base + 1] - dexit_c[ebase]), 64'(1));
            end
        end

        begin
            int n = 0;
            rise_cyc[0] = -1;
            send(0, 32'hFFFF_FFFB, 32'd9, 4);
            rr[0] = 0; v[1] = 1; a[1] = 32'd2; b[1] = 32'd8; next_k = 2;
            while (rise_cyc[0] < 0 && n < 50) begin step(); n++; end
            repeat (5) begin
                step();
                chk("hold_valid", 64'(bus.rsp0_valid), 64'(1));
                chk("hold_data", bus.rsp_data, 64'hFFFF_FFFF_FFFF_FFD3);
                chk("hold_no_accept", 64'(bus.req1_ready), 64'(0));
            end
            rr[0] = 1; n = 0;
            do begin step(); n++; end while (!accepted[1] && n < 20);
            v[1] = 0;
            chk("hold_gap", 64'(dacc_c[$] - dexit_c[$]), 64'(1));
            wait_idle();
        end

        begin
            int base;
            send(0, 32'd11, 32'd13, 20);
            repeat (5) step();
            chk("mid_busy", 64'(bus.busy), 64'(1));
            rst_n = 0;
            step();
            rst_n = 1;
            chk("post_rst_busy", 64'(bus.busy), 64'(0));
            chk("post_rst_rsp0", 64'(bus.rsp0_valid), 64'(0));
            chk("post_rst_sticky", 64'(bus.err_timeout), 64'(0));
            base = dacc_p.size();
            v = '{1, 1}; next_k = 3;
            step();
            v = '{0, 0};
            chk("ptr_accept", 64'(dacc_p.size() - base), 64'(1));
            if (dacc_p.size() > base) chk("ptr_port0", 64'(dacc_p[$]), 64'(0));
            wait_idle();
        end

        rise_cyc[0] = -1;
        send(0, 32'd5, 32'd5, 1000);
        wait_idle();
        chk("to_latency", 64'(rise_cyc[0] - dacc_c[$]), 64'(33));
        chk("to_data", rise_data[0], 64'(0));
        chk("to_err", 64'(rise_err[0]), 64'(1));
        rise_cyc[1] = -1;
        send(1, 32'h8000_0000, 32'h8000_0000, 6);
        wait_idle();
        chk("after_to_data", rise_data[1], 64'h4000_0000_0000_0000);
        chk("after_to_err", 64'(rise_err[1]), 64'(0));
        chk("after_to_sticky", 64'(bus.err_timeout), 64'(1));

        begin
            int n = 0;
            spur = 1;
            repeat (3) step();
            spur = 0;
            rise_cyc[0] = -1;
            send(0, 32'h0001_2345, 32'hFFFF_FFF0, 31);
            rr[0] = 0;
            while (rise_cyc[0] < 0 && n < 50) begin step(); n++; end
            chk("tie_latency", 64'(rise_cyc[0] - dacc_c[$]), 64'(33));
            chk("tie_err", 64'(rise_err[0]), 64'(0));
            spur = 1;
            repeat (3) step();
            chk("spur_resp_data", bus.rsp_data, 64'hFFFF_FFFF_FFED_CBB0);
            spur = 0; rr[0] = 1;
            wait_idle();
        end

        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!v[p] && $urandom_range(0, 3) == 0) begin v[p] = 1; a[p] = $urandom; b[p] = $urandom; end
                rr[p] = $urandom_range(0, 3) != 0;
            end
            if (!out_q) next_k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(28, 36)) : int'($urandom_range(1, 12));
            spur = $urandom_range(0, 4) == 0;
            step();
            for (int p = 0; p < 2; p++) if (accepted[p]) v[p] = 0;
        end
        v = '{0, 0}; rr = '{1, 1}; spur = 0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
